// File: rtl/sample_collect_16_pkg.sv
// Shared constants and helpers for the 16-slot sample collector.
package sample_collect_16_pkg;

    localparam int N_SLOTS = 16;
    localparam int IDX_W   = 4;
    localparam int CNT_W   = 5;

    // Keep mask for a frame of len real samples: bit i set when i < len.
    function automatic logic [N_SLOTS-1:0] slot_mask(input logic [CNT_W-1:0] len);
        logic [N_SLOTS-1:0] mask;
        mask = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            mask[i] = (CNT_W'(i) < len);
        end
        return mask;
    endfunction

endpackage

// File: rtl/sample_collect_16_if.sv
// Sample stream in, parallel frame out; master drives samples, slave is the collector.
interface sample_collect_16_if
    import sample_collect_16_pkg::*;
#(
    parameter int W = 32
);

    logic                   s_valid;
    logic                   s_ready;
    logic [W-1:0]           s_data;
    logic                   s_last;
    logic                   m_valid;
    logic                   m_ready;
    logic [N_SLOTS*W-1:0]   m_data;
    logic [CNT_W-1:0]       m_count;

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_count
    );

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, m_count
    );

endinterface

// File: rtl/sample_collect_16.sv
// Packs a W-bit sample stream into 16-slot frames using a fill bank and a held output bank.
module sample_collect_16
    import sample_collect_16_pkg::*;
#(
    parameter int           W   = 32,
    parameter logic [W-1:0] PAD = {W{1'b0}}
) (
    input  logic                 clk,
    input  logic                 reset_b,
    sample_collect_16_if.slave   bus
);

    logic [W-1:0]          fill [N_SLOTS];
    logic [IDX_W-1:0]      wr_idx;
    logic                  fill_full;
    logic [CNT_W-1:0]      pend_len;
    logic                  m_valid_q;
    logic [N_SLOTS*W-1:0]  m_data_q;
    logic [CNT_W-1:0]      m_count_q;

    logic                  accept;
    logic                  complete;
    logic                  out_free;
    logic [CNT_W-1:0]      cur_len;
    logic [CNT_W-1:0]      len_sel;
    logic [N_SLOTS-1:0]    keep;
    logic [W-1:0]          slot;
    logic [N_SLOTS*W-1:0]  frame_next;

    assign accept   = bus.s_valid && !fill_full;
    assign complete = accept && ((wr_idx == IDX_W'(N_SLOTS - 1)) || bus.s_last);
    assign out_free = !m_valid_q || bus.m_ready;
    assign cur_len  = CNT_W'(wr_idx) + CNT_W'(1);
    assign len_sel  = fill_full ? pend_len : cur_len;

    assign bus.s_ready = !fill_full;
    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;
    assign bus.m_count = m_count_q;

    // The incoming sample is merged in only on a direct completion; a drained bank is already complete.
    always_comb begin
        frame_next = '0;
        slot       = '0;
        keep       = slot_mask(len_sel);
        for (int i = 0; i < N_SLOTS; i++) begin
            slot = fill[i];
            if (!fill_full && (IDX_W'(i) == wr_idx)) begin
                slot = bus.s_data;
            end
            frame_next[i*W +: W] = keep[i] ? slot : PAD;
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            for (int i = 0; i < N_SLOTS; i++) begin
                fill[i] <= '0;
            end
            wr_idx    <= '0;
            fill_full <= 1'b0;
            pend_len  <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_count_q <= '0;
        end else begin
            if (accept) begin
                fill[wr_idx] <= bus.s_data;
            end

            if (complete) begin
                if (out_free) begin
                    m_data_q  <= frame_next;
                    m_count_q <= cur_len;
                    m_valid_q <= 1'b1;
                    wr_idx    <= '0;
                end else begin
                    // Output bank still held: park the finished frame until it drains.
                    fill_full <= 1'b1;
                    pend_len  <= cur_len;
                end
            end else begin
                if (accept) begin
                    wr_idx <= wr_idx + IDX_W'(1);
                end
                if (m_valid_q && bus.m_ready) begin
                    if (fill_full) begin
                        m_data_q  <= frame_next;
                        m_count_q <= pend_len;
                        fill_full <= 1'b0;
                        wr_idx    <= '0;
                    end else begin
                        m_valid_q <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: doc/sample_collect_16.md
Name: sample_collect_16

Overview:
Stream-to-frame collector that produces the 16-wide parallel sample vector consumed by the 16-input pipelined max tree. It accepts W-bit samples one per cycle on a valid/ready stream and packs them into 16 slots. Complete frames are presented on a held output bank under a valid/ready frame handshake. A fill bank plus an output bank gives sustained one-sample-per-cycle throughput.

Parameters:
W, 32, sample width in bits
PAD, {W{1'b0}}, value written into unused slots of a short frame (0 is neutral for an unsigned max)

Ports:
clk  input  1  clock
reset_b  input  1  asynchronous active-low reset
s_valid  input  1  sample valid
s_ready  output  1  collector can accept a sample
s_data  input  W  sample value
s_last  input  1  sample closes the frame early (short frame)
m_valid  output  1  output bank holds a complete frame
m_ready  input  1  downstream accepts the frame
m_data  output  16*W  slot i at m_data[i*W +: W]; slot 0 is the first sample of the frame
m_count  output  5  number of real samples in the frame, 1..16

Behaviour:
- Reset: reset_b is asynchronous and active-low; clock is clk.
  - While reset is asserted: m_valid=0, m_data=0, m_count=0, write index=0, fill_full=0.
  - The partial frame in the fill bank is discarded.
- Acceptance: a sample is accepted when s_valid && s_ready at the rising edge.
  - s_ready = !fill_full (combinational).
- Fill bank: 16 × W registers plus a 4-bit write index wr_idx.
  - An accepted sample is written to fill[wr_idx] and wr_idx increments.
- Frame completion: the accepted sample has wr_idx==15, or s_last=1. Both together count as one completion.
  - Frame length L = wr_idx+1.
- Output bank is free in a cycle when !m_valid || m_ready.
- Completion with output bank free:
  - At that same edge, out bank <= fill contents including the incoming sample.
  - Slots L..15 <= PAD.
  - m_count <= L, m_valid <= 1, wr_idx <= 0.
  - Latency: m_valid is visible the cycle after the completing sample.
- Completion with output bank busy:
  - The completing sample is stored, fill_full <= 1 and s_ready drops.
  - The pending L is kept in a register.
- Draining a full fill bank: at the edge where m_valid && m_ready && fill_full:
  - Out bank <= fill bank (padded), m_count <= pending L, m_valid stays 1.
  - fill_full <= 0 and wr_idx <= 0; s_ready returns high the next cycle.
- Frame release without a pending frame: m_valid && m_ready && !fill_full && no completion this edge -> m_valid <= 0.
- Simultaneous events:
  - Completion and m_ready in the same cycle counts as bank free: back-to-back frames with m_valid continuously high.
  - Sustained throughput is 16 samples per 16 cycles with m_ready tied high.
- Holding rules:
  - m_data and m_count are stable while m_valid && !m_ready.
  - m_data is never modified except at a transfer edge.
- s_last on the very first sample gives a frame with L=1, slot 0=sample, slots 1..15=PAD.
- Ignored inputs: s_data and s_last are ignored when s_valid=0. The s_ready=0 case needs no special handling, since no acceptance occurs.
- Reset mid-frame or with fill_full set: everything returns to reset values and no frame is emitted.
- All state is held in registers; the only combinational output is s_ready.

Decomposition:
- Shared package holds:
  - N_SLOTS=16, IDX_W=4, CNT_W=5.
  - Function slot_mask(L) returning a 16-bit keep mask (bit i set when i<L), used for padding.
- Single module; no sub-module needed. The two register banks are plain arrays inside it.

Test Plan:
- Reset, then 16 samples 1..16 back-to-back with m_ready=1 -> m_valid high the cycle after sample 16; slot i = i+1; m_count=16; s_ready stays 1 throughout.
- 3 samples 0xA,0xB,0xC with s_last on 0xC, PAD=0 -> slots 0..2 = A,B,C; slots 3..15 = 0; m_count=3.
- m_ready=0, stream 32 samples continuously -> first frame held stable; s_ready drops after sample 32. Raise m_ready for one cycle -> frame 2 (values 17..32) appears on the next cycle with m_valid still high, and s_ready rises again.
- 64 samples with m_ready=1, s_valid=1 every cycle -> 4 frames, with m_valid pulses one cycle each at 16-cycle spacing; no sample lost or duplicated.
- Random s_valid gaps (50%) across 5 frames -> output frames match a reference queue in order and content.
- Assert reset_b low after 7 samples of a frame, release, then send 16 samples -> no frame from the 7 samples; the next frame contains only the new 16 samples.
